// File: rtl/adc_pkg.sv
// adc_pkg: shared types and helpers for the serial ADC reader.
//   adc_state_e     - controller FSM states
//   SCLK_IDLE       - SCLK level outside a burst
//   SCLK_SAMPLE_LVL - SCLK level driven on the edge where Dout is captured
//   lane_lsb()      - LSB position of a lane's word in the packed data bus
package adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    WAIT_HI,
    WAIT_LO,
    CS_SETUP,
    SHIFT,
    DONE
  } adc_state_e;

  localparam logic SCLK_IDLE       = 1'b1;
  localparam logic SCLK_SAMPLE_LVL = 1'b1;

  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned bits);
    return lane * bits;
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// adc_sclk_gen: SCLK divider and edge-strobe generator.
// While en_i is high, SCLK toggles every SCLK_DIV clocks, first edge falling.
// Once stop_i is high with SCLK at the sample level, the next tick raises
// end_o instead of toggling, so SCLK is parked high.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   en_i          run the divider; low reloads it and parks SCLK at idle
//   stop_i        suppress further falling edges (burst length reached)
//   sclk_o        registered SCLK level
//   rise_o        this cycle drives SCLK high (capture cycle)
//   fall_o        this cycle drives SCLK low
//   end_o         tick on which the burst would have fallen but stop_i held it
//   edge_cnt_o    rising edges since en_i went high
module adc_sclk_gen
  import adc_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 2,
  parameter int unsigned CW       = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          stop_i,
  output logic          sclk_o,
  output logic          rise_o,
  output logic          fall_o,
  output logic          end_o,
  output logic [CW-1:0] edge_cnt_o
);
  localparam int unsigned   DW       = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LOAD = DW'(SCLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;
  logic          at_sample;

  always_comb begin
    tick      = en_i && (div_q == '0);
    at_sample = (sclk_q == SCLK_SAMPLE_LVL);
    rise_o    = tick && !at_sample;
    fall_o    = tick && at_sample && !stop_i;
    end_o     = tick && at_sample && stop_i;
    div_d     = div_q;
    sclk_d    = sclk_q;
    cnt_d     = cnt_q;
    if (!en_i) begin
      div_d  = DIV_LOAD;
      sclk_d = SCLK_IDLE;
      cnt_d  = '0;
    end else if (tick) begin
      div_d = DIV_LOAD;
      if (rise_o) begin
        sclk_d = SCLK_SAMPLE_LVL;
        cnt_d  = cnt_q + CW'(1);
      end else if (fall_o) begin
        sclk_d = ~SCLK_SAMPLE_LVL;
      end
    end else begin
      div_d = div_q - DW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q  <= DIV_LOAD;
      sclk_q <= SCLK_IDLE;
      cnt_q  <= '0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sclk_o     = sclk_q;
  assign edge_cnt_o = cnt_q;

endmodule

// File: rtl/adc_serial_reader.sv
// adc_serial_reader: CNVST/BUSY multi-lane serial ADC controller.
// On start: pulse CNVST low, wait out BUSY, then clock LANES data lines in
// parallel over one SCLK burst and present all words with a valid strobe.
// Optional build macro ADC_AVG_EN: one start runs 2^AVG_LOG2 conversions and
// data_out carries the truncated per-lane average.
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   start         conversion request, honoured in IDLE only
//   BUSY_ADC      ADC busy (asynchronous, synchronised here)
//   Dout_ADC      serial data, bit k = lane k
//   CNVST_ADC     conversion start, active low
//   CS_ADC        chip select, active low
//   SCLK_ADC      serial clock, idles high
//   data_out      lane k in [k*BITS +: BITS]
//   valid         one-cycle strobe, data_out updated
//   ready         high in IDLE
//   timeout_err   one-cycle strobe on BUSY timeout
//
// state    | meaning
// IDLE     | ready, waiting for start
// CONV     | CNVST low for CNV_LOW cycles
// WAIT_HI  | waiting for synchronised BUSY to rise
// WAIT_LO  | waiting for synchronised BUSY to fall
// CS_SETUP | CS low, SCLK high for SCLK_DIV cycles
// SHIFT    | SCLK burst, lanes captured on rising edges
// DONE     | data_out loaded, valid high
module adc_serial_reader
  import adc_pkg::*;
#(
  parameter int unsigned LANES        = 2,
  parameter int unsigned BITS         = 14,
  parameter int unsigned SCLK_DIV     = 2,
  parameter int unsigned CNV_LOW      = 3,
  parameter int unsigned BUSY_TIMEOUT = 200
`ifdef ADC_AVG_EN
  ,parameter int unsigned AVG_LOG2    = 2
`endif
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  BUSY_ADC,
  input  logic [LANES-1:0]      Dout_ADC,
  output logic                  CNVST_ADC,
  output logic                  CS_ADC,
  output logic                  SCLK_ADC,
  output logic [LANES*BITS-1:0] data_out,
  output logic                  valid,
  output logic                  ready,
  output logic                  timeout_err
);
  localparam int unsigned       CNV_W     = $clog2(CNV_LOW + 1);
  localparam int unsigned       TO_W      = $clog2(BUSY_TIMEOUT + 1);
  localparam int unsigned       EDGE_W    = $clog2(BITS + 1);
  localparam logic [CNV_W-1:0]  CNV_LOAD  = CNV_W'(CNV_LOW - 1);
  localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(BUSY_TIMEOUT - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(BITS);

  adc_state_e state_q, state_d;
  logic busy_s1_q, busy_s2_q;
  logic [CNV_W-1:0] cnv_cnt_q, cnv_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic cnvst_q, cnvst_d, cs_q, cs_d, valid_q, valid_d, ready_q, ready_d, terr_q, terr_d;
  logic [LANES*BITS-1:0] data_q, result_w;
  logic load_data, last_conv, batch_start, shift_done;
  logic sclk_en, sclk_stop, sclk_rise, sclk_fall, sclk_end;
  logic [EDGE_W-1:0] edge_cnt;

  adc_sclk_gen #(.SCLK_DIV(SCLK_DIV), .CW(EDGE_W)) u_sclk (
    .clk_i      (CLK),
    .rst_i      (RST),
    .en_i       (sclk_en),
    .stop_i     (sclk_stop),
    .sclk_o     (SCLK_ADC),
    .rise_o     (sclk_rise),
    .fall_o     (sclk_fall),
    .end_o      (sclk_end),
    .edge_cnt_o (edge_cnt)
  );

  assign sclk_en     = (state_q == CS_SETUP) || (state_q == SHIFT);
  assign sclk_stop   = (edge_cnt == EDGE_LAST);
  assign batch_start = (state_q == IDLE) && start;
  assign shift_done  = (state_q == SHIFT) && sclk_end;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [BITS-1:0] sh_q;
    always_ff @(posedge CLK) begin
      if (RST)            sh_q <= '0;
      else if (sclk_rise) sh_q <= {sh_q[BITS-2:0], Dout_ADC[k]};
    end
`ifdef ADC_AVG_EN
    logic [BITS+AVG_LOG2-1:0] acc_q, acc_sum;
    assign acc_sum = acc_q + {{AVG_LOG2{1'b0}}, sh_q};
    always_ff @(posedge CLK) begin
      if (RST || batch_start) acc_q <= '0;
      else if (shift_done)    acc_q <= acc_sum;
    end
    // Final word is folded in combinationally so the average is ready on the same edge.
    assign result_w[lane_lsb(k, BITS) +: BITS] = acc_sum[AVG_LOG2 +: BITS];
`else
    assign result_w[lane_lsb(k, BITS) +: BITS] = sh_q;
`endif
  end

`ifdef ADC_AVG_EN
  localparam int unsigned       CONV_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'((1 << AVG_LOG2) - 1);
  logic [CONV_W-1:0] conv_q;
  always_ff @(posedge CLK) begin
    if (RST || batch_start) conv_q <= '0;
    else if (shift_done)    conv_q <= conv_q + CONV_W'(1);
  end
  assign last_conv = (conv_q == CONV_LAST);
`else
  assign last_conv = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    cnv_cnt_d = cnv_cnt_q;
    to_cnt_d  = to_cnt_q;
    terr_d    = 1'b0;
    load_data = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d   = CONV;
        cnv_cnt_d = CNV_LOAD;
        to_cnt_d  = TO_LOAD;
      end
      CONV, WAIT_HI, WAIT_LO: begin
        if (to_cnt_q == '0) begin
          state_d = IDLE;
          terr_d  = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q - TO_W'(1);
          if (state_q == CONV) begin
            if (cnv_cnt_q == '0) state_d = WAIT_HI;
            else cnv_cnt_d = cnv_cnt_q - CNV_W'(1);
          end else if (state_q == WAIT_HI) begin
            if (busy_s2_q) state_d = WAIT_LO;
          end else if (!busy_s2_q) begin
            state_d = CS_SETUP;
          end
        end
      end
      CS_SETUP: if (sclk_fall) state_d = SHIFT;
      SHIFT: if (sclk_end) begin
        if (last_conv) begin
          state_d   = DONE;
          load_data = 1'b1;
        end else begin
          state_d   = CONV;
          cnv_cnt_d = CNV_LOAD;
          to_cnt_d  = TO_LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Pins are decoded from the next state and registered so they never glitch.
    cnvst_d = (state_d != CONV);
    cs_d    = !((state_d == CS_SETUP) || (state_d == SHIFT));
    ready_d = (state_d == IDLE);
    valid_d = load_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      busy_s1_q <= 1'b0;
      busy_s2_q <= 1'b0;
      cnv_cnt_q <= '0;
      to_cnt_q  <= '0;
      cnvst_q   <= 1'b1;
      cs_q      <= 1'b1;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      terr_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      busy_s1_q <= BUSY_ADC;
      busy_s2_q <= busy_s1_q;
      cnv_cnt_q <= cnv_cnt_d;
      to_cnt_q  <= to_cnt_d;
      cnvst_q   <= cnvst_d;
      cs_q      <= cs_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      terr_q    <= terr_d;
      if (load_data) data_q <= result_w;
    end
  end

  assign CNVST_ADC   = cnvst_q;
  assign CS_ADC      = cs_q;
  assign data_out    = data_q;
  assign valid       = valid_q;
  assign ready       = ready_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_adc_serial_reader.sv
// Scoreboard bench for adc_serial_reader: stimulus pushes expected events,
// a negedge monitor pops them when valid or timeout_err is presented.
module tb_adc_serial_reader;
  localparam int LANES = 2;
  localparam int BITS  = 14;
  localparam int W     = LANES * BITS;
  // ADC output delay after SCLK fall; kept under the 20 ns SCLK half-period
  // so each bit is settled before the capturing edge.
  localparam int DOUT_DLY = 18;

  logic clk, RST, start, BUSY_ADC;
  logic [LANES-1:0] Dout_ADC;
  logic CNVST_ADC, CS_ADC, SCLK_ADC, valid, ready, timeout_err;
  logic [W-1:0] data_out;

  adc_serial_reader dut (
    .CLK(clk), .RST(RST), .start(start), .BUSY_ADC(BUSY_ADC), .Dout_ADC(Dout_ADC),
    .CNVST_ADC(CNVST_ADC), .CS_ADC(CS_ADC), .SCLK_ADC(SCLK_ADC), .data_out(data_out),
    .valid(valid), .ready(ready), .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic         is_to;
    logic [W-1:0] val;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0, n_fail = 0;
  int vcount = 0, rise_cnt = 0, cyc = 0, cnv_fall_cyc = 0;
  int wsel = 0, bit_idx = 0, dout_idx = 0;
  bit busy_en = 1'b1;
  logic [BITS-1:0] wa[4], wb[4];
  logic [BITS-1:0] cur_a, cur_b;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ADC model: BUSY pulse after CNVST fall, one word per CS frame, MSB first.
  initial begin
    BUSY_ADC = 1'b0;
    forever begin
      @(negedge CNVST_ADC);
      cnv_fall_cyc = cyc;
      if (busy_en) begin
        #40 BUSY_ADC = 1'b1;
        #700 BUSY_ADC = 1'b0;
      end
    end
  end

  always @(negedge CS_ADC) begin
    cur_a   = wa[wsel];
    cur_b   = wb[wsel];
    wsel    = (wsel + 1) % 4;
    bit_idx = 0;
  end

  initial begin
    Dout_ADC = '0;
    forever begin
      @(negedge SCLK_ADC);
      if (CS_ADC === 1'b0 && bit_idx < BITS) begin
        dout_idx = bit_idx;
        bit_idx++;
        #(DOUT_DLY);
        Dout_ADC = {cur_b[BITS-1-dout_idx], cur_a[BITS-1-dout_idx]};
      end
    end
  end

  always @(posedge SCLK_ADC) if (CS_ADC === 1'b0) rise_cnt++;

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (valid === 1'b1 || timeout_err === 1'b1) begin
      if (valid === 1'b1) vcount++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got valid=%0b timeout_err=%0b, expected none", valid, timeout_err);
      end else begin
        e = sb_q.pop_front();
        check("event_kind_timeout", 64'(timeout_err), 64'(e.is_to));
        if (e.is_to) check("timeout_delay", 64'(cyc - cnv_fall_cyc), 64'(e.val));
        else         check("data_out", 64'(data_out), 64'(e.val));
      end
    end
  end

  task automatic push_exp(input logic is_to, input logic [W-1:0] v);
    exp_t e;
    e.is_to = is_to;
    e.val   = v;
    sb_q.push_back(e);
  endtask

  task automatic set_words(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    for (int i = 0; i < 4; i++) begin
      wa[i] = a;
      wb[i] = b;
    end
    wsel = 0;
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int maxc);
    int c = 0;
    while ((sb_q.size() != 0 || ready !== 1'b1) && c < maxc) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (c >= maxc) begin
      n_fail++;
      $display("FAIL %s: no completion after %0d cycles, %0d events pending, expected 0", name, c, sb_q.size());
    end
  endtask

  initial begin
    int v0;
    int c;
    RST = 1'b1;
    start = 1'b0;
    set_words('0, '0);

    // 1: reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk) RST = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_cnvst", 64'(CNVST_ADC), 64'(1));
    check("idle_cs", 64'(CS_ADC), 64'(1));
    check("idle_sclk", 64'(SCLK_ADC), 64'(1));
    check("idle_ready", 64'(ready), 64'(1));
    check("idle_data", 64'(data_out), 64'(0));
    check("idle_valid_count", 64'(vcount), 64'(0));

    // 2: nominal conversion
    set_words(14'h2A5C, 14'h1F03);
    rise_cnt = 0;
    push_exp(1'b0, {14'h1F03, 14'h2A5C});
    do_start();
    wait_done("nominal_done", 2500);
    check("nominal_valid_count", 64'(vcount), 64'(1));
    check("nominal_ready", 64'(ready), 64'(1));
`ifndef ADC_AVG_EN
    check("nominal_sclk_rises", 64'(rise_cnt), 64'(14));
`endif

    // 3: BUSY tied low -> timeout, then a normal conversion
    busy_en = 1'b0;
    rise_cnt = 0;
    push_exp(1'b1, W'(200));
    do_start();
    wait_done("timeout_done", 600);
    check("timeout_sclk_rises", 64'(rise_cnt), 64'(0));
    check("timeout_cs", 64'(CS_ADC), 64'(1));
    busy_en = 1'b1;
    set_words(14'h3FFF, 14'h0001);
    push_exp(1'b0, {14'h0001, 14'h3FFF});
    do_start();
    wait_done("after_timeout_done", 2500);

    // 4: start while busy is ignored
    set_words(14'h0000, 14'h2AAA);
    v0 = vcount;
    push_exp(1'b0, {14'h2AAA, 14'h0000});
    do_start();
    repeat (50) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done("restart_ignored_done", 2500);
    repeat (300) @(negedge clk);
    check("restart_valid_count", 64'(vcount - v0), 64'(1));

    // 5: reset mid-SHIFT
    set_words(14'h1234, 14'h0ABC);
    v0 = vcount;
    rise_cnt = 0;
    do_start();
    c = 0;
    while (rise_cnt < 5 && c < 600) begin
      @(negedge clk);
      c++;
    end
    check("midshift_reached", 64'(rise_cnt >= 5), 64'(1));
    RST = 1'b1;
    @(negedge clk);
    check("midshift_rst_cs", 64'(CS_ADC), 64'(1));
    check("midshift_rst_sclk", 64'(SCLK_ADC), 64'(1));
    check("midshift_rst_data", 64'(data_out), 64'(0));
    check("midshift_rst_valid", 64'(valid), 64'(0));
    RST = 1'b0;
    repeat (200) @(negedge clk);
    check("midshift_no_valid", 64'(vcount - v0), 64'(0));
    check("midshift_ready", 64'(ready), 64'(1));

`ifdef ADC_AVG_EN
    // 6: averaging of four conversions, truncated
    wa[0] = 14'd100; wa[1] = 14'd101; wa[2] = 14'd102; wa[3] = 14'd105;
    wb[0] = 14'd0;   wb[1] = 14'd1;   wb[2] = 14'd2;   wb[3] = 14'd3;
    wsel = 0;
    v0 = vcount;
    push_exp(1'b0, {14'd1, 14'd102});
    do_start();
    wait_done("avg_done", 3000);
    check("avg_valid_count", 64'(vcount - v0), 64'(1));
`endif

    repeat (10) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
